// File: rtl/axis_maxpool_window_pad_pkg.sv
// Shared geometry, types and word helpers for the windowed width-direction max-pool stage.
package axis_maxpool_window_pad_pkg;

  localparam int UNITS       = 8;
  localparam int GROUPS      = 2;
  localparam int COPIES      = 2;
  localparam int WORD_WIDTH  = 8;
  localparam int KW_MAX      = 3;
  localparam int PAD_MAX     = 1;
  localparam int UNITS_EDGES = UNITS + 2 * PAD_MAX;

  localparam int NGRP      = COPIES * GROUPS;
  localparam int IN_W      = NGRP * UNITS * WORD_WIDTH;
  localparam int OUT_WORDS = NGRP * UNITS_EDGES;
  localparam int OUT_W     = OUT_WORDS * WORD_WIDTH;
  localparam int KW_W      = $clog2(KW_MAX + 1);
  localparam int PAD_W     = $clog2(PAD_MAX + 1);
  localparam int HIST_N    = KW_MAX - 1;
  localparam int HCNT_W    = $clog2(KW_MAX);

  typedef logic signed [WORD_WIDTH-1:0] word_t;
  typedef logic [IN_W-1:0] col_t;

  localparam word_t WORD_MIN = {1'b1, {(WORD_WIDTH-1){1'b0}}};

  typedef enum logic {ST_ROW_START, ST_IN_ROW} row_state_e;

  typedef struct packed {
    row_state_e          state;
    logic [KW_W-1:0]     wait_cnt;
    logic [HCNT_W-1:0]   hist_cnt;
  } dbg_t;

  function automatic int flat_idx(input int grp, input int pos, input int per_grp);
    return grp * per_grp + pos;
  endfunction

  function automatic word_t smax(input word_t a, input word_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_maxpool_window_pad_if.sv
// Input column stream and pooled output stream of the max-pool stage, bundled for one port.
interface axis_maxpool_window_pad_if;
  import axis_maxpool_window_pad_pkg::*;

  // valid/ready: a beat moves on the rising edge where tvalid && tready are both high; a
  // producer never waits for tready before raising tvalid and holds the beat until it moves.
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  col_t                 s_axis_tdata;
  logic                 s_axis_tlast;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [OUT_W-1:0]     m_axis_tdata;
  logic [OUT_WORDS-1:0] m_axis_tkeep;
  logic                 m_axis_tlast;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

endinterface

// File: rtl/maxpool_window_max.sv
// Element-wise signed max of the current column and the newest n_hist history columns.
module maxpool_window_max
  import axis_maxpool_window_pad_pkg::*;
(
  input  col_t              cur,
  input  col_t              hist [HIST_N],
  input  logic [HCNT_W-1:0] n_hist,
  output col_t              pooled
);

  col_t acc;

  always_comb begin
    acc = cur;
    for (int h = 0; h < HIST_N; h++) begin
      if (HCNT_W'(h) < n_hist) begin
        for (int w = 0; w < NGRP * UNITS; w++) begin
          acc[w*WORD_WIDTH +: WORD_WIDTH] = smax(word_t'(acc[w*WORD_WIDTH +: WORD_WIDTH]),
                                                 word_t'(hist[h][w*WORD_WIDTH +: WORD_WIDTH]));
        end
      end
    end
    pooled = acc;
  end

endmodule

// File: rtl/axis_maxpool_window_pad.sv
// Streaming width-direction max-pool with per-row window, stride and edge padding;
// one registered output column per emitting input beat.
module axis_maxpool_window_pad
  import axis_maxpool_window_pad_pkg::*;
(
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [KW_W-1:0]  cfg_kw,
  input  logic [KW_W-1:0]  cfg_sw,
  input  logic [PAD_W-1:0] cfg_pad,
  input  logic             cfg_pad_min,
  axis_maxpool_window_pad_if.slave axis,
  output dbg_t             dbg
);

  row_state_e           state_q, state_d;
  logic [KW_W-1:0]      wait_q, wait_d, kw_q, sw_q, kw_e, sw_e, wait_e;
  logic [PAD_W-1:0]     pad_q, pad_e;
  logic                 pad_min_q, pad_min_e;
  logic [HCNT_W-1:0]    hcnt_q, hcnt_d, hcnt_e, span, n_hist;
  col_t                 hist_q [HIST_N];
  col_t                 pooled;
  logic                 row_start, accept, emit;
  logic                 m_valid_q, m_last_q;
  logic [OUT_W-1:0]     m_data_q, pad_data;
  logic [OUT_WORDS-1:0] m_keep_q, pad_keep;

  function automatic logic [KW_W-1:0] clamp_win(input logic [KW_W-1:0] v);
    if (v == '0) return KW_W'(1);
    if (v > KW_W'(KW_MAX)) return KW_W'(KW_MAX);
    return v;
  endfunction

  function automatic int edge_dist(input int e);
    return (e < PAD_MAX) ? (PAD_MAX - e) : (e - (PAD_MAX + UNITS) + 1);
  endfunction

  assign row_start          = (state_q == ST_ROW_START);
  assign axis.s_axis_tready = !m_valid_q || axis.m_axis_tready;
  assign accept             = axis.s_axis_tvalid && axis.s_axis_tready;

  // The first beat of a row sees the live cfg inputs; later beats see the latched copy.
  assign kw_e      = row_start ? clamp_win(cfg_kw) : kw_q;
  assign sw_e      = row_start ? clamp_win(cfg_sw) : sw_q;
  assign pad_e     = row_start ? ((cfg_pad > PAD_W'(PAD_MAX)) ? PAD_W'(PAD_MAX) : cfg_pad) : pad_q;
  assign pad_min_e = row_start ? cfg_pad_min : pad_min_q;
  assign wait_e    = row_start ? kw_e - KW_W'(1) : wait_q;
  assign hcnt_e    = row_start ? '0 : hcnt_q;
  assign emit      = (wait_e == '0) || axis.s_axis_tlast;

  // History columns belonging to the window in progress; an early tlast cuts the window short.
  always_comb begin
    span = '0;
    if (wait_e < kw_e) span = HCNT_W'(kw_e - wait_e - KW_W'(1));
    n_hist = (span < hcnt_e) ? span : hcnt_e;
  end

  maxpool_window_max u_window_max (
    .cur    (axis.s_axis_tdata),
    .hist   (hist_q),
    .n_hist (n_hist),
    .pooled (pooled)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    hcnt_d  = hcnt_q;
    if (accept) begin
      if (axis.s_axis_tlast) begin
        state_d = ST_ROW_START;
        wait_d  = '0;
        hcnt_d  = '0;
      end else begin
        state_d = ST_IN_ROW;
        wait_d  = emit ? sw_e - KW_W'(1) : wait_e - KW_W'(1);
        hcnt_d  = (hcnt_e == HCNT_W'(HIST_N)) ? hcnt_e : hcnt_e + HCNT_W'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q   <= ST_ROW_START;
      wait_q    <= '0;
      hcnt_q    <= '0;
      kw_q      <= '0;
      sw_q      <= '0;
      pad_q     <= '0;
      pad_min_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      hcnt_q  <= hcnt_d;
      if (accept && row_start) begin
        kw_q      <= kw_e;
        sw_q      <= sw_e;
        pad_q     <= pad_e;
        pad_min_q <= pad_min_e;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < HIST_N; i++) hist_q[i] <= '0;
    end else if (accept) begin
      if (axis.s_axis_tlast) begin
        for (int i = 0; i < HIST_N; i++) hist_q[i] <= '0;
      end else begin
        hist_q[0] <= axis.s_axis_tdata;
        for (int i = 1; i < HIST_N; i++) hist_q[i] <= hist_q[i-1];
      end
    end
  end

  always_comb begin
    pad_data = '0;
    pad_keep = '0;
    for (int g = 0; g < NGRP; g++) begin
      for (int e = 0; e < UNITS_EDGES; e++) begin
        if (e >= PAD_MAX && e < PAD_MAX + UNITS) begin
          pad_data[flat_idx(g, e, UNITS_EDGES)*WORD_WIDTH +: WORD_WIDTH] =
            pooled[flat_idx(g, e - PAD_MAX, UNITS)*WORD_WIDTH +: WORD_WIDTH];
          pad_keep[flat_idx(g, e, UNITS_EDGES)] = 1'b1;
        end else if (edge_dist(e) <= int'(pad_e)) begin
          pad_data[flat_idx(g, e, UNITS_EDGES)*WORD_WIDTH +: WORD_WIDTH] = pad_min_e ? WORD_MIN : '0;
          pad_keep[flat_idx(g, e, UNITS_EDGES)] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
    end else if (accept && emit) begin
      m_valid_q <= 1'b1;
      m_last_q  <= axis.s_axis_tlast;
      m_data_q  <= pad_data;
      m_keep_q  <= pad_keep;
    end else if (axis.m_axis_tready) begin
      m_valid_q <= 1'b0;
    end
  end

  assign axis.m_axis_tvalid = m_valid_q;
  assign axis.m_axis_tlast  = m_last_q;
  assign axis.m_axis_tdata  = m_data_q;
  assign axis.m_axis_tkeep  = m_keep_q;
  assign dbg = '{state: state_q, wait_cnt: wait_q, hist_cnt: hcnt_q};

endmodule

// File: tb/tb_axis_maxpool_window_pad.sv
// Bench for axis_maxpool_window_pad: directed rows, backpressure, mid-row reset and a random
// stream, all checked against a row-buffer pooling model through an expected-output queue.
module tb_axis_maxpool_window_pad;
  import axis_maxpool_window_pad_pkg::*;

  localparam int WW      = WORD_WIDTH;
  localparam int EXP_W   = 1 + OUT_WORDS + OUT_W;
  localparam int TIMEOUT = 200;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [KW_W-1:0]  cfg_kw = '0;
  logic [KW_W-1:0]  cfg_sw = '0;
  logic [PAD_W-1:0] cfg_pad = '0;
  logic             cfg_pad_min = 1'b0;
  dbg_t             dbg;

  axis_maxpool_window_pad_if bus();

  axis_maxpool_window_pad dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .cfg_kw      (cfg_kw),
    .cfg_sw      (cfg_sw),
    .cfg_pad     (cfg_pad),
    .cfg_pad_min (cfg_pad_min),
    .axis        (bus.slave),
    .dbg         (dbg)
  );

  // clock / reset
  always #5 aclk = ~aclk;

  int               n_vec = 0;
  int               n_err = 0;
  logic [EXP_W-1:0] exp_q[$];
  bit               stall = 1'b0;
  bit               ready_always = 1'b0;
  int               gap_max = 0;

  // reference model state: columns of the current row and the cfg latched at its start
  col_t row_cols[$];
  int   m_kw, m_sw, m_pad;
  logic m_pmin;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic col_t rep(input int v);
    col_t c;
    for (int w = 0; w < NGRP * UNITS; w++) c[w*WW +: WW] = v[WW-1:0];
    return c;
  endfunction

  function automatic col_t rand_col();
    col_t c;
    for (int w = 0; w < NGRP * UNITS; w++) c[w*WW +: WW] = WW'($urandom_range(0, 255));
    return c;
  endfunction

  // Pooling windows are [i-kw+1, i] at i = kw-1 + m*sw; a row-ending beat elsewhere closes
  // the window that covers it (or stands alone if it falls in a skipped gap).
  task automatic model_accept(input col_t d, input logic last, input int kw, input int sw,
                              input int pad, input logic pmin, output bit emit);
    int i, start, p, mx, v, pmv, base;
    bit normal;
    logic [OUT_W-1:0]     od;
    logic [OUT_WORDS-1:0] ok;
    if (row_cols.size() == 0) begin
      m_kw   = (kw == 0) ? 1 : ((kw > KW_MAX) ? KW_MAX : kw);
      m_sw   = (sw == 0) ? 1 : ((sw > KW_MAX) ? KW_MAX : sw);
      m_pad  = (pad > PAD_MAX) ? PAD_MAX : pad;
      m_pmin = pmin;
    end
    row_cols.push_back(d);
    i = row_cols.size() - 1;
    normal = (i >= m_kw - 1) && (((i - (m_kw - 1)) % m_sw) == 0);
    emit = normal || last;
    if (emit) begin
      if (normal) start = i - m_kw + 1;
      else begin
        p = (i < m_kw - 1) ? m_kw - 1 : m_kw - 1 + ((i - (m_kw - 1) + m_sw - 1) / m_sw) * m_sw;
        start = p - m_kw + 1;
        if (start > i) start = i;
      end
      od  = '0;
      ok  = '0;
      pmv = m_pmin ? -(1 << (WW - 1)) : 0;
      for (int cg = 0; cg < NGRP; cg++) begin
        base = cg * UNITS_EDGES;
        for (int u = 0; u < UNITS; u++) begin
          mx = int'($signed(row_cols[start][(cg*UNITS+u)*WW +: WW]));
          for (int j = start + 1; j <= i; j++) begin
            v = int'($signed(row_cols[j][(cg*UNITS+u)*WW +: WW]));
            if (v > mx) mx = v;
          end
          od[(base+PAD_MAX+u)*WW +: WW] = mx[WW-1:0];
          ok[base+PAD_MAX+u] = 1'b1;
        end
        for (int k = 1; k <= m_pad; k++) begin
          od[(base+PAD_MAX-k)*WW +: WW]         = pmv[WW-1:0];
          od[(base+PAD_MAX+UNITS-1+k)*WW +: WW] = pmv[WW-1:0];
          ok[base+PAD_MAX-k]         = 1'b1;
          ok[base+PAD_MAX+UNITS-1+k] = 1'b1;
        end
      end
      exp_q.push_back({last, ok, od});
    end
    if (last) row_cols.delete();
  endtask

  // driver: called at a negedge; cfg is scrambled on non-first beats since only the row start counts
  task automatic drive_beat(input col_t d, input logic last, input int kw, input int sw,
                            input int pad, input int pmin);
    bit done, emit;
    done = 1'b0;
    emit = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = last;
    if (row_cols.size() == 0) begin
      cfg_kw = KW_W'(kw); cfg_sw = KW_W'(sw); cfg_pad = PAD_W'(pad); cfg_pad_min = pmin[0];
    end else begin
      cfg_kw = KW_W'($urandom); cfg_sw = KW_W'($urandom);
      cfg_pad = PAD_W'($urandom); cfg_pad_min = 1'($urandom);
    end
    for (int t = 0; t < TIMEOUT && !done; t++) begin
      #1;
      if (bus.s_axis_tready) begin
        model_accept(d, last, int'(cfg_kw), int'(cfg_sw), int'(cfg_pad), cfg_pad_min, emit);
        done = 1'b1;
      end
      @(negedge aclk);
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: beat not accepted within %0d cycles", TIMEOUT);
    end else if (emit) begin
      chk("latency_tvalid", bus.m_axis_tvalid, 1'b1);
    end
    bus.s_axis_tvalid = 1'b0;
    repeat ($urandom_range(0, gap_max)) @(negedge aclk);
  endtask

  task automatic drain();
    ready_always = 1'b1;
    for (int t = 0; t < TIMEOUT && exp_q.size() != 0; t++) @(negedge aclk);
    chk("drain_left", exp_q.size(), 0);
  endtask

  // monitor / scoreboard
  initial begin
    logic [EXP_W-1:0] act, prev_word;
    bit prev_stall;
    prev_stall = 1'b0;
    prev_word  = '0;
    bus.m_axis_tready = 1'b0;
    forever begin
      @(negedge aclk);
      if (stall) bus.m_axis_tready = 1'b0;
      else if (ready_always) bus.m_axis_tready = 1'b1;
      else bus.m_axis_tready = ($urandom_range(0, 3) != 0);
      #2;
      if (!aresetn) begin
        prev_stall = 1'b0;
        continue;
      end
      act = {bus.m_axis_tlast, bus.m_axis_tkeep, bus.m_axis_tdata};
      if (prev_stall) chk("hold_output", act, prev_word);
      if (bus.m_axis_tvalid && !bus.m_axis_tready) chk("stall_s_tready", bus.s_axis_tready, 1'b0);
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output: got %h with nothing expected", act);
        end else begin
          chk("output", act, exp_q.pop_front());
        end
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_word  = act;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int beats, len, kw, sw, pad, pmin;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    repeat (3) @(negedge aclk);
    chk("rst_m_tvalid", bus.m_axis_tvalid, 1'b0);
    chk("rst_m_tlast",  bus.m_axis_tlast, 1'b0);
    chk("rst_m_tdata",  bus.m_axis_tdata, '0);
    chk("rst_m_tkeep",  bus.m_axis_tkeep, '0);
    chk("rst_s_tready", bus.s_axis_tready, 1'b1);
    aresetn = 1'b1;
    @(negedge aclk);
    ready_always = 1'b1;

    // kw=3 sw=1: 1,5,2,7 -> 5, 7(last)
    drive_beat(rep(1), 1'b0, 3, 1, 0, 0);
    drive_beat(rep(5), 1'b0, 3, 1, 0, 0);
    drive_beat(rep(2), 1'b0, 3, 1, 0, 0);
    drive_beat(rep(7), 1'b1, 3, 1, 0, 0);
    // kw=2 sw=2: -3,-1,4,9,6 -> -1, 9, 6(last)
    drive_beat(rep(-3), 1'b0, 2, 2, 0, 0);
    drive_beat(rep(-1), 1'b0, 2, 2, 0, 0);
    drive_beat(rep(4),  1'b0, 2, 2, 0, 0);
    drive_beat(rep(9),  1'b0, 2, 2, 0, 0);
    drive_beat(rep(6),  1'b1, 2, 2, 0, 0);
    // padding variants
    drive_beat(rand_col(), 1'b0, 1, 1, 1, 1);
    drive_beat(rand_col(), 1'b1, 1, 1, 1, 1);
    drive_beat(rand_col(), 1'b1, 1, 1, 0, 1);
    drive_beat(rand_col(), 1'b1, 1, 1, 1, 0);
    // clamping: kw=0/sw=0 -> 1/1, kw=3/sw=0 -> 3/1, sw > kw skipping
    for (int n = 0; n < 3; n++) drive_beat(rand_col(), n == 2, 0, 0, 1, 1);
    for (int n = 0; n < 5; n++) drive_beat(rand_col(), n == 4, 3, 0, 1, 0);
    for (int n = 0; n < 7; n++) drive_beat(rand_col(), n == 6, 1, 3, 0, 0);

    // backpressure on a kw=1 stream
    ready_always = 1'b0;
    fork
      for (int n = 0; n < 12; n++)
        drive_beat(rand_col(), n == 11, 1, 1, $urandom_range(0, 1), $urandom_range(0, 1));
      begin
        repeat (4) @(negedge aclk);
        stall = 1'b1;
        repeat (5) @(negedge aclk);
        stall = 1'b0;
      end
    join
    drain();

    // reset while an output is held and a row is half done
    stall = 1'b1;
    drive_beat(rand_col(), 1'b0, 1, 1, 0, 0);
    @(negedge aclk);
    chk("pre_rst_m_tvalid", bus.m_axis_tvalid, 1'b1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", bus.m_axis_tvalid, 1'b0);
    chk("mid_rst_m_tkeep",  bus.m_axis_tkeep, '0);
    exp_q.delete();
    row_cols.delete();
    @(negedge aclk);
    aresetn = 1'b1;
    stall = 1'b0;
    @(negedge aclk);
    for (int n = 0; n < 5; n++) drive_beat(rand_col(), n == 4, 3, 2, 1, 1);
    drain();

    // random stream
    ready_always = 1'b0;
    gap_max = 2;
    beats = 0;
    while (beats < 1000) begin
      len  = $urandom_range(1, 8);
      kw   = $urandom_range(0, 3);
      sw   = $urandom_range(0, 3);
      pad  = $urandom_range(0, 1);
      pmin = $urandom_range(0, 1);
      for (int n = 0; n < len; n++) drive_beat(rand_col(), n == len - 1, kw, sw, pad, pmin);
      beats += len;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
